ram_sync_nxm: RTL



---
 rtl/ram_sync_nxm_pkg.sv | 25 ++
 rtl/ram_sync_nxm_if.sv | 35 +++
 rtl/ram_sync_clr_ctrl.sv | 56 +++++
 rtl/ram_sync_nxm.sv | 103 ++++++++++
 4 files changed

// File: rtl/ram_sync_nxm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_sync_pkg
// Brief   : Shared types, access encodings and parity helper for ram_sync_nxm.
// Revision: 1.0 - initial release
// ============================================================================
package ram_sync_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  localparam int PARITY_MAX_W = 64;

  // Returns the bit that makes the word's total count of ones even.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sync_nxm_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_sync_nxm_if
// Brief   : Access bus of the single-port synchronous RAM (master = requester).
// Revision: 1.0 - initial release
// ============================================================================
interface ram_sync_nxm_if #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic             sel;
  logic             rw;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] din;
  logic             clr;
  logic             perr_inj;
  logic [WIDTH-1:0] dout;
  logic             dvalid;
  logic             busy;
  logic             perr;

  modport master (
    output sel, rw, addr, din, clr, perr_inj,
    input  dout, dvalid, busy, perr
  );

  modport slave (
    input  sel, rw, addr, din, clr, perr_inj,
    output dout, dvalid, busy, perr
  );

endinterface
`default_nettype wire

// File: rtl/ram_sync_clr_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_sync_clr_ctrl
// Brief   : IDLE/CLEAR sequencer; sweeps a zero-write pointer over the whole
//           array after reset release or on a clr request.
// Revision: 1.0 - initial release
// ============================================================================
module ram_sync_clr_ctrl #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);
  import ram_sync_pkg::*;

  localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

  state_t        r_state;
  logic [AW-1:0] r_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= CLEAR;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (r_ptr == c_LAST) begin
            r_state <= IDLE;
            r_ptr   <= '0;
          end else begin
            r_ptr <= r_ptr + 1'b1;
          end
        end
        default: begin
          if (clr) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
          end
        end
      endcase
    end
  end

  assign busy     = (r_state == CLEAR);
  // The array must stay untouched while reset is held.
  assign clr_we   = busy & reset;
  assign clr_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/ram_sync_nxm.sv
`default_nettype none
// ============================================================================
// Module  : ram_sync_nxm
// Brief   : DEPTH x WIDTH single-port synchronous RAM, registered read with
//           dvalid, automatic clear sweep. Define PARITY_EN to store an even
//           parity bit per word (WIDTH must then be < 64).
// Revision: 1.0 - initial release
// ============================================================================
module ram_sync_nxm #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           reset,
  ram_sync_nxm_if.slave bus
);
  import ram_sync_pkg::*;

  localparam int AW = $clog2(DEPTH);
`ifdef PARITY_EN
  localparam int c_MW = WIDTH + 1;
`else
  localparam int c_MW = WIDTH;
`endif
  localparam logic [AW:0] c_DEPTH_EXT = (AW + 1)'(DEPTH);

  logic          w_busy;
  logic          w_clr_we;
  logic [AW-1:0] w_clr_addr;

  ram_sync_clr_ctrl #(
    .DEPTH (DEPTH)
  ) u_clr_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clr      (bus.clr),
    .busy     (w_busy),
    .clr_we   (w_clr_we),
    .clr_addr (w_clr_addr)
  );

  logic [c_MW-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;
  logic             r_dvalid;
  logic             r_perr;

  logic             w_in_range;
  logic             w_access;
  logic             w_wr;
  logic             w_rd;
  logic [c_MW-1:0]  w_wr_word;
  logic [c_MW-1:0]  w_rd_word;
  logic             w_rd_perr;

  assign w_in_range = ({1'b0, bus.addr} < c_DEPTH_EXT);
  // A pending clr wins over a same-cycle access, which is then dropped.
  assign w_access   = reset & ~w_busy & ~bus.clr & bus.sel;
  assign w_wr       = w_access & (bus.rw == RW_WRITE) & w_in_range;
  assign w_rd       = w_access & (bus.rw == RW_READ);
  assign w_rd_word  = w_in_range ? r_mem[bus.addr] : '0;

`ifdef PARITY_EN
  assign w_wr_word = {even_parity(PARITY_MAX_W'(bus.din)) ^ bus.perr_inj, bus.din};
  // Parity over data plus stored parity bit is 1 exactly when they disagree.
  assign w_rd_perr = even_parity(PARITY_MAX_W'(w_rd_word));
`else
  logic w_unused_perr_inj;
  assign w_unused_perr_inj = bus.perr_inj;
  assign w_wr_word         = bus.din;
  assign w_rd_perr         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[w_clr_addr] <= '0;
    end else if (w_wr) begin
      r_mem[bus.addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_perr   <= 1'b0;
    end else if (w_rd) begin
      r_dout   <= w_rd_word[WIDTH-1:0];
      r_dvalid <= 1'b1;
      r_perr   <= w_rd_perr & w_in_range;
    end else begin
      r_dout   <= '0;
      r_dvalid <= 1'b0;
      r_perr   <= 1'b0;
    end
  end

  assign bus.dout   = r_dout;
  assign bus.dvalid = r_dvalid;
  assign bus.perr   = r_perr;
  assign bus.busy   = w_busy;

endmodule
`default_nettype wire
